// File: rtl/mrv32_pkg.sv
// Shared write-back types and constants for the mrv32 core.
// Holds the round-robin index helper used by the write-back arbiter.
package mrv32_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] REG_X0 = 5'd0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    // (base + off) mod n for base < n and off < n, without a divider
    function automatic int rr_wrap(input int base, input int off, input int n);
        int sum;
        sum = base + off;
        return (sum >= n) ? (sum - n) : sum;
    endfunction

endpackage

// File: rtl/mrv32_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr_i,
// wrapping modulo NUM_REQ. The pointer register lives in the instantiating block.
module mrv32_rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [PTR_W-1:0]   gnt_idx_o,
    output logic               gnt_vld_o
);
    import mrv32_pkg::*;

    // Scan from the pointer; the first hit wins and masks all later candidates
    always_comb begin
        logic [PTR_W-1:0] cand;
        logic             hit;
        gnt_o     = '0;
        gnt_idx_o = '0;
        gnt_vld_o = 1'b0;
        cand      = '0;
        hit       = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand          = PTR_W'(rr_wrap(int'(ptr_i), k, NUM_REQ));
            hit           = en_i && !gnt_vld_o && req_i[cand];
            gnt_o[cand]   = gnt_o[cand] | hit;
            gnt_idx_o     = hit ? cand : gnt_idx_o;
            gnt_vld_o     = gnt_vld_o | hit;
        end
    end

endmodule

// File: rtl/mrv32_wb_arbiter.sv
// Round-robin arbiter sharing the integer register-file write port, with one output stage.
// Define MRV32_WB_FWD_EN to forward the staged entry onto the rs1/rs2 read data.
module mrv32_wb_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*REG_ADDR_W-1:0] req_rd_addr,
    input  logic [NUM_REQ*XLEN-1:0]       req_rd_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          rf_stall,
    output logic                          rf_wen,
    output logic [REG_ADDR_W-1:0]         rf_rd_addr,
    output logic [XLEN-1:0]               rf_rd_data,
    input  logic [REG_ADDR_W-1:0]         rs1_addr,
    input  logic [REG_ADDR_W-1:0]         rs2_addr,
    input  logic [XLEN-1:0]               rf_rs1_data,
    input  logic [XLEN-1:0]               rf_rs2_data,
    output logic [XLEN-1:0]               rs1_data,
    output logic [XLEN-1:0]               rs2_data,
    output logic                          wb_busy
);
    import mrv32_pkg::*;

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic                  stg_vld_q,  stg_vld_d;
    logic [REG_ADDR_W-1:0] stg_addr_q, stg_addr_d;
    logic [XLEN-1:0]       stg_data_q, stg_data_d;
    logic [PTR_W-1:0]      rr_ptr_q,   rr_ptr_d;

    logic                  accept_ok;
    logic                  arb_en;
    logic [NUM_REQ-1:0]    gnt;
    logic [PTR_W-1:0]      gnt_idx;
    logic                  gnt_vld;
    logic                  stg_nz;

    // A full stage only makes room when it is draining this cycle
    assign accept_ok = !stg_vld_q || !rf_stall;
    assign arb_en    = accept_ok && !rst;

    mrv32_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .req_i     (req_valid),
        .ptr_i     (rr_ptr_q),
        .en_i      (arb_en),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .gnt_vld_o (gnt_vld)
    );

    assign req_ready = gnt;

    // Stage load on grant, otherwise drain when the RF port is free
    always_comb begin
        stg_vld_d  = stg_vld_q;
        stg_addr_d = stg_addr_q;
        stg_data_d = stg_data_q;
        rr_ptr_d   = rr_ptr_q;
        if (gnt_vld) begin
            stg_vld_d  = 1'b1;
            stg_addr_d = req_rd_addr[gnt_idx*REG_ADDR_W +: REG_ADDR_W];
            stg_data_d = req_rd_data[gnt_idx*XLEN +: XLEN];
            rr_ptr_d   = PTR_W'(rr_wrap(int'(gnt_idx), 1, NUM_REQ));
        end else if (stg_vld_q && !rf_stall) begin
            stg_vld_d  = 1'b0;
        end else begin
            stg_vld_d  = stg_vld_q;
        end
    end

    // Stage and round-robin pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            stg_vld_q  <= 1'b0;
            stg_addr_q <= '0;
            stg_data_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            stg_vld_q  <= stg_vld_d;
            stg_addr_q <= stg_addr_d;
            stg_data_q <= stg_data_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign stg_nz     = (stg_addr_q != REG_ADDR_W'(REG_X0));
    assign rf_wen     = stg_vld_q && !rf_stall && stg_nz && !rst;
    assign rf_rd_addr = stg_vld_q ? stg_addr_q : '0;
    assign rf_rd_data = stg_vld_q ? stg_data_q : '0;
    assign wb_busy    = stg_vld_q;

`ifdef MRV32_WB_FWD_EN
    // Forwarding is independent of rf_stall: a held entry is still the newest value
    assign rs1_data = (stg_vld_q && stg_nz && (rs1_addr == stg_addr_q)) ? stg_data_q : rf_rs1_data;
    assign rs2_data = (stg_vld_q && stg_nz && (rs2_addr == stg_addr_q)) ? stg_data_q : rf_rs2_data;
`else
    logic fwd_unused;
    assign fwd_unused = ^{rs1_addr, rs2_addr};
    assign rs1_data   = rf_rs1_data;
    assign rs2_data   = rf_rs2_data;
`endif

endmodule

// File: tb/tb_mrv32_wb_arbiter.sv
// Self-checking bench for mrv32_wb_arbiter: directed scenarios plus a randomized
// run against a transaction-level reference model of the write-back stage.
module tb_mrv32_wb_arbiter;

    localparam int N  = 3;
    localparam int AW = 5;
    localparam int XW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_rd_addr;
    logic [N*XW-1:0] req_rd_data;
    logic [N-1:0]    req_ready;
    logic            rf_stall;
    logic            rf_wen;
    logic [AW-1:0]   rf_rd_addr;
    logic [XW-1:0]   rf_rd_data;
    logic [AW-1:0]   rs1_addr, rs2_addr;
    logic [XW-1:0]   rf_rs1_data, rf_rs2_data;
    logic [XW-1:0]   rs1_data, rs2_data;
    logic            wb_busy;

    int n_cmp = 0;
    int n_err = 0;

    // reference model: one pending write and the source that has priority next
    logic          m_vld  = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [XW-1:0] m_data = '0;
    int            m_ptr  = 0;

    int            e_gnt;
    logic [N-1:0]  e_ready;
    logic          e_wen;
    logic [AW-1:0] e_addr;
    logic [XW-1:0] e_data;
    logic [XW-1:0] e_rs1, e_rs2;

    mrv32_wb_arbiter #(.NUM_REQ(N), .XLEN(XW), .REG_ADDR_W(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_rd_addr (req_rd_addr),
        .req_rd_data (req_rd_data),
        .req_ready   (req_ready),
        .rf_stall    (rf_stall),
        .rf_wen      (rf_wen),
        .rf_rd_addr  (rf_rd_addr),
        .rf_rd_data  (rf_rd_data),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rf_rs1_data (rf_rs1_data),
        .rf_rs2_data (rf_rs2_data),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .wb_busy     (wb_busy)
    );

    always #5 clk = ~clk;

    task automatic model_eval();
        e_gnt   = -1;
        e_ready = '0;
        if (!rst && (!m_vld || !rf_stall)) begin
            for (int k = 0; k < N; k++) begin
                int s;
                s = (m_ptr + k) % N;
                if (e_gnt < 0 && req_valid[s]) e_gnt = s;
            end
        end
        if (e_gnt >= 0) e_ready[e_gnt] = 1'b1;
        e_wen  = !rst && m_vld && !rf_stall && (m_addr != 5'd0);
        e_addr = m_vld ? m_addr : 5'd0;
        e_data = m_vld ? m_data : 32'd0;
`ifdef MRV32_WB_FWD_EN
        e_rs1 = (m_vld && m_addr != 5'd0 && rs1_addr == m_addr) ? m_data : rf_rs1_data;
        e_rs2 = (m_vld && m_addr != 5'd0 && rs2_addr == m_addr) ? m_data : rf_rs2_data;
`else
        e_rs1 = rf_rs1_data;
        e_rs2 = rf_rs2_data;
`endif
    endtask

    // advance one clock; inputs are held from the preceding falling edge
    task automatic tick();
        model_eval();
        @(posedge clk);
        if (rst) begin
            m_vld = 1'b0; m_addr = '0; m_data = '0; m_ptr = 0;
        end else if (e_gnt >= 0) begin
            m_vld  = 1'b1;
            m_addr = req_rd_addr[e_gnt*AW +: AW];
            m_data = req_rd_data[e_gnt*XW +: XW];
            m_ptr  = (e_gnt + 1) % N;
        end else if (m_vld && !rf_stall) begin
            m_vld = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 3'b111; rf_stall = 1'b0;
        tick(); tick();
        #1;
        n_cmp++; if (req_ready !== 3'b000) begin n_err++; $display("FAIL reset_ready got %b exp 000", req_ready); end
        n_cmp++; if (rf_wen !== 1'b0) begin n_err++; $display("FAIL reset_wen got %b exp 0", rf_wen); end
        n_cmp++; if (wb_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", wb_busy); end
        rst = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 3'b001) begin n_err++; $display("FAIL reset_first_grant got %b exp 001", req_ready); end
        req_valid = 3'b000;
        tick();
    endtask

    task automatic test_single_write();
        req_valid = 3'b010;
        req_rd_addr[1*AW +: AW] = 5'd5;
        req_rd_data[1*XW +: XW] = 32'hDEAD_BEEF;
        #1;
        n_cmp++; if (req_ready !== 3'b010) begin n_err++; $display("FAIL single_ready got %b exp 010", req_ready); end
        tick();
        req_valid = 3'b000;
        #1;
        n_cmp++; if ({rf_wen, rf_rd_addr, rf_rd_data} !== {1'b1, 5'd5, 32'hDEAD_BEEF}) begin
            n_err++; $display("FAIL single_write got wen=%b addr=%0d data=%h exp wen=1 addr=5 data=deadbeef", rf_wen, rf_rd_addr, rf_rd_data);
        end
        tick();
        #1;
        n_cmp++; if ({wb_busy, rf_wen} !== 2'b00) begin n_err++; $display("FAIL single_drain got busy=%b wen=%b exp 0 0", wb_busy, rf_wen); end
    endtask

    task automatic test_fairness();
        logic [N-1:0]  exp_rdy;
        logic [AW-1:0] exp_addr;
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            req_rd_addr[i*AW +: AW] = AW'(i + 1);
            req_rd_data[i*XW +: XW] = XW'(32'h1111_0000 + i);
        end
        req_valid = 3'b111;
        for (int i = 0; i < 6; i++) begin
            #1;
            exp_rdy = 3'b001 << (i % N);
            n_cmp++; if (req_ready !== exp_rdy) begin n_err++; $display("FAIL fair_grant[%0d] got %b exp %b", i, req_ready, exp_rdy); end
            if (i > 0) begin
                exp_addr = AW'(((i - 1) % N) + 1);
                n_cmp++; if ({rf_wen, rf_rd_addr} !== {1'b1, exp_addr}) begin
                    n_err++; $display("FAIL fair_write[%0d] got wen=%b addr=%0d exp wen=1 addr=%0d", i, rf_wen, rf_rd_addr, exp_addr);
                end
            end
            tick();
        end
        req_valid = 3'b000;
        tick();
    endtask

    task automatic test_x0_write();
        req_valid = 3'b001;
        req_rd_addr[0 +: AW] = 5'd0;
        req_rd_data[0 +: XW] = 32'h0000_1234;
        #1;
        n_cmp++; if (req_ready !== 3'b001) begin n_err++; $display("FAIL x0_ready got %b exp 001", req_ready); end
        tick();
        req_valid = 3'b000;
        #1;
        n_cmp++; if ({wb_busy, rf_wen} !== 2'b10) begin n_err++; $display("FAIL x0_stage got busy=%b wen=%b exp busy=1 wen=0", wb_busy, rf_wen); end
        tick();
        #1;
        n_cmp++; if ({wb_busy, rf_wen} !== 2'b00) begin n_err++; $display("FAIL x0_drain got busy=%b wen=%b exp 0 0", wb_busy, rf_wen); end
    endtask

    task automatic test_stall();
        req_valid = 3'b100;
        req_rd_addr[2*AW +: AW] = 5'd9;
        req_rd_data[2*XW +: XW] = 32'hCAFE_F00D;
        tick();
        req_valid = 3'b111; rf_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if ({req_ready, rf_wen, wb_busy, rf_rd_addr, rf_rd_data} !== {3'b000, 1'b0, 1'b1, 5'd9, 32'hCAFE_F00D}) begin
                n_err++; $display("FAIL stall_hold[%0d] got rdy=%b wen=%b busy=%b addr=%0d data=%h exp rdy=000 wen=0 busy=1 addr=9 data=cafef00d",
                                  i, req_ready, rf_wen, wb_busy, rf_rd_addr, rf_rd_data);
            end
            tick();
        end
        rf_stall = 1'b0; req_valid = 3'b000;
        #1;
        n_cmp++; if ({rf_wen, rf_rd_addr} !== {1'b1, 5'd9}) begin n_err++; $display("FAIL stall_release got wen=%b addr=%0d exp wen=1 addr=9", rf_wen, rf_rd_addr); end
        tick();
        // an empty stage still accepts one entry under stall
        rf_stall = 1'b1; req_valid = 3'b001; req_rd_addr[0 +: AW] = 5'd3;
        #1;
        n_cmp++; if (req_ready !== 3'b001) begin n_err++; $display("FAIL stall_empty_accept got %b exp 001", req_ready); end
        tick();
        #1;
        n_cmp++; if ({req_ready, rf_wen, wb_busy} !== {3'b000, 1'b0, 1'b1}) begin
            n_err++; $display("FAIL stall_full_block got rdy=%b wen=%b busy=%b exp 000 0 1", req_ready, rf_wen, wb_busy);
        end
        rf_stall = 1'b0; req_valid = 3'b000;
        tick();
    endtask

    task automatic test_forwarding();
        logic [XW-1:0] exp_rs1;
        req_valid = 3'b010;
        req_rd_addr[1*AW +: AW] = 5'd7;
        req_rd_data[1*XW +: XW] = 32'hA5A5_A5A5;
        tick();
        req_valid = 3'b000; rf_stall = 1'b1;
        rs1_addr = 5'd7; rf_rs1_data = 32'd0;
        rs2_addr = 5'd0; rf_rs2_data = 32'h1357_9BDF;
`ifdef MRV32_WB_FWD_EN
        exp_rs1 = 32'hA5A5_A5A5;
`else
        exp_rs1 = 32'd0;
`endif
        #1;
        n_cmp++; if (rs1_data !== exp_rs1) begin n_err++; $display("FAIL fwd_rs1 got %h exp %h", rs1_data, exp_rs1); end
        n_cmp++; if (rs2_data !== 32'h1357_9BDF) begin n_err++; $display("FAIL fwd_rs2_x0 got %h exp 13579bdf", rs2_data); end
        rf_stall = 1'b0;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst       = ($urandom_range(0, 99) < 2);
            rf_stall  = ($urandom_range(0, 99) < 30);
            req_valid = N'($urandom_range(0, 7));
            for (int i = 0; i < N; i++) begin
                req_rd_addr[i*AW +: AW] = ($urandom_range(0, 3) == 0) ? 5'd0 : AW'($urandom_range(1, 31));
                req_rd_data[i*XW +: XW] = $urandom;
            end
            rs1_addr    = ($urandom_range(0, 1) == 1) ? m_addr : AW'($urandom_range(0, 31));
            rs2_addr    = ($urandom_range(0, 1) == 1) ? m_addr : AW'($urandom_range(0, 31));
            rf_rs1_data = $urandom;
            rf_rs2_data = $urandom;
            #1;
            model_eval();
            n_cmp++; if (req_ready !== e_ready) begin n_err++; $display("FAIL rand_ready cyc %0d got %b exp %b", c, req_ready, e_ready); end
            n_cmp++; if (rf_wen !== e_wen) begin n_err++; $display("FAIL rand_wen cyc %0d got %b exp %b", c, rf_wen, e_wen); end
            n_cmp++; if ({rf_rd_addr, rf_rd_data} !== {e_addr, e_data}) begin
                n_err++; $display("FAIL rand_rfport cyc %0d got %0d/%h exp %0d/%h", c, rf_rd_addr, rf_rd_data, e_addr, e_data);
            end
            n_cmp++; if (wb_busy !== m_vld) begin n_err++; $display("FAIL rand_busy cyc %0d got %b exp %b", c, wb_busy, m_vld); end
            n_cmp++; if ({rs1_data, rs2_data} !== {e_rs1, e_rs2}) begin
                n_err++; $display("FAIL rand_rsdata cyc %0d got %h/%h exp %h/%h", c, rs1_data, rs2_data, e_rs1, e_rs2);
            end
            tick();
        end
        rst = 1'b0; rf_stall = 1'b0; req_valid = 3'b000;
        tick();
    endtask

    initial begin
        rst = 1'b1; rf_stall = 1'b0; req_valid = '0;
        req_rd_addr = '0; req_rd_data = '0;
        rs1_addr = '0; rs2_addr = '0; rf_rs1_data = '0; rf_rs2_data = '0;
        @(negedge clk);
        test_reset();
        test_single_write();
        test_fairness();
        test_x0_write();
        test_stall();
        test_forwarding();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
